// File: rtl/he_hssi_kpi_csr_if.sv
// Host CSR bus between the HE-HSSI CSR bridge (master) and the KPI block (slave).
interface he_hssi_kpi_csr_if;
    logic [15:0] csr_addr;
    logic        csr_wr;
    logic        csr_rd;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;

    modport master (
        output csr_addr, csr_wr, csr_rd, csr_wdata,
        input  csr_rdata, csr_rvalid
    );

    modport slave (
        input  csr_addr, csr_wr, csr_rd, csr_wdata,
        output csr_rdata, csr_rvalid
    );
endinterface

// File: rtl/he_hssi_kpi_csr.sv
// CSR responder and KPI statistics engine for the HE-HSSI traffic generator and
// traffic monitor: TG configuration, start pulse, packet counters and timestamps.
module he_hssi_kpi_csr #(
    parameter int TS_W    = 32,
    parameter int CNT_W   = 32,
    parameter int LEN_W   = 14,
    parameter int LEN_RST = 64
) (
    input  logic             clk,
    input  logic             rst,
    he_hssi_kpi_csr_if.slave csr,
    output logic [31:0]      tg_num_pkt_o,
    output logic [1:0]       tg_pattern_o,
    output logic [LEN_W-1:0] tg_pkt_len_o,
    output logic             tg_start_o,
    input  logic             tg_pkt_sent_i,
    input  logic             tm_pkt_good_i,
    input  logic             tm_pkt_bad_i,
    output logic             busy_o
);

    localparam logic [15:0] ADDR_NUM_PKT   = 16'hE000;
    localparam logic [15:0] ADDR_PATTERN   = 16'hE008;
    localparam logic [15:0] ADDR_START     = 16'hE00C;
    localparam logic [15:0] ADDR_PKT_LEN   = 16'hE034;
    localparam logic [15:0] ADDR_TG_END_TS = 16'hE3D0;
    localparam logic [15:0] ADDR_GOOD      = 16'hE404;
    localparam logic [15:0] ADDR_BAD       = 16'hE408;
    localparam logic [15:0] ADDR_TM_ST_TS  = 16'hE42C;
    localparam logic [15:0] ADDR_TM_END_TS = 16'hE430;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [31:0]       num_pkt_q;
    logic [1:0]        pattern_q;
    logic [LEN_W-1:0]  pkt_len_q;
    logic              tg_start_q;
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   tg_end_ts_q;
    logic [TS_W-1:0]   tm_start_ts_q;
    logic [TS_W-1:0]   tm_end_ts_q;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0]  bad_q, bad_d;
    logic [32:0]       rx_total_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q;
    logic              run;
    logic              start_req;
    logic              rx_pulse;

    // Saturating counter increments and the read-data mux, all from current state
    always_comb begin
        run        = (state_q == RUN);
        start_req  = csr.csr_wr && (csr.csr_addr == ADDR_START) && csr.csr_wdata[0] && !run;
        rx_pulse   = run && (tm_pkt_good_i || tm_pkt_bad_i);
        tx_cnt_d   = tx_cnt_q;
        good_d     = good_q;
        bad_d      = bad_q;
        if (run && tg_pkt_sent_i && (tx_cnt_q != '1)) tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (run && tm_pkt_good_i && (good_q != '1))   good_d   = good_q + CNT_W'(1);
        if (run && tm_pkt_bad_i && (bad_q != '1))     bad_d    = bad_q + CNT_W'(1);
        rx_total_d = 33'(good_d) + 33'(bad_d);

        rdata_d = '0;
        case (csr.csr_addr)
            ADDR_NUM_PKT:   rdata_d = num_pkt_q;
            ADDR_PATTERN:   rdata_d = 32'(pattern_q);
            ADDR_START:     rdata_d = {30'b0, state_q == DONE, state_q == RUN};
            ADDR_PKT_LEN:   rdata_d = 32'(pkt_len_q);
            ADDR_TG_END_TS: rdata_d = 32'(tg_end_ts_q);
            ADDR_GOOD:      rdata_d = 32'(good_q);
            ADDR_BAD:       rdata_d = 32'(bad_q);
            ADDR_TM_ST_TS:  rdata_d = 32'(tm_start_ts_q);
            ADDR_TM_END_TS: rdata_d = 32'(tm_end_ts_q);
            default:        rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            num_pkt_q     <= '0;
            pattern_q     <= '0;
            pkt_len_q     <= LEN_W'(LEN_RST);
            tg_start_q    <= 1'b0;
            ts_q          <= '0;
            tg_end_ts_q   <= '0;
            tm_start_ts_q <= '0;
            tm_end_ts_q   <= '0;
            tx_cnt_q      <= '0;
            good_q        <= '0;
            bad_q         <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            ts_q       <= ts_q + TS_W'(1);
            tg_start_q <= start_req;
            rvalid_q   <= csr.csr_rd;
            if (csr.csr_rd) rdata_q <= rdata_d;

            if (csr.csr_wr) begin
                case (csr.csr_addr)
                    ADDR_NUM_PKT: num_pkt_q <= csr.csr_wdata;
                    ADDR_PATTERN: pattern_q <= csr.csr_wdata[1:0];
                    ADDR_PKT_LEN: pkt_len_q <= csr.csr_wdata[LEN_W-1:0];
                    default: ;
                endcase
            end

            // NUM_PKT is compared live, so a zero count finishes after one RUN cycle
            case (state_q)
                IDLE, DONE: begin
                    if (start_req) begin
                        state_q       <= RUN;
                        tx_cnt_q      <= '0;
                        good_q        <= '0;
                        bad_q         <= '0;
                        tg_end_ts_q   <= '0;
                        tm_start_ts_q <= '0;
                        tm_end_ts_q   <= '0;
                    end
                end
                RUN: begin
                    tx_cnt_q <= tx_cnt_d;
                    good_q   <= good_d;
                    bad_q    <= bad_d;
                    if (tg_pkt_sent_i && (32'(tx_cnt_d) == num_pkt_q)) tg_end_ts_q <= ts_q;
                    if (rx_pulse) begin
                        if ((good_q == '0) && (bad_q == '0)) tm_start_ts_q <= ts_q;
                        tm_end_ts_q <= ts_q;
                    end
                    if (rx_total_d >= 33'(num_pkt_q)) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tg_num_pkt_o   = num_pkt_q;
    assign tg_pattern_o   = pattern_q;
    assign tg_pkt_len_o   = pkt_len_q;
    assign tg_start_o     = tg_start_q;
    assign busy_o         = (state_q == RUN);
    assign csr.csr_rdata  = rdata_q;
    assign csr.csr_rvalid = rvalid_q;

endmodule

// File: tb/tb_he_hssi_kpi_csr.sv
// Directed bench for he_hssi_kpi_csr; read data is checked through a scoreboard
// queue filled when a read is issued and drained when rvalid appears.
module tb_he_hssi_kpi_csr;
    localparam int LEN_W = 14;

    localparam logic [15:0] A_NUM   = 16'hE000;
    localparam logic [15:0] A_PAT   = 16'hE008;
    localparam logic [15:0] A_START = 16'hE00C;
    localparam logic [15:0] A_LEN   = 16'hE034;
    localparam logic [15:0] A_TGEND = 16'hE3D0;
    localparam logic [15:0] A_GOOD  = 16'hE404;
    localparam logic [15:0] A_BAD   = 16'hE408;
    localparam logic [15:0] A_TMST  = 16'hE42C;
    localparam logic [15:0] A_TMEND = 16'hE430;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } rd_exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      tg_num_pkt;
    logic [1:0]       tg_pattern;
    logic [LEN_W-1:0] tg_pkt_len;
    logic             tg_start;
    logic             tg_pkt_sent;
    logic             tm_pkt_good;
    logic             tm_pkt_bad;
    logic             busy;

    rd_exp_t expQ[$];
    int errors     = 0;
    int checks     = 0;
    int edgeNo     = 0;
    int rstEdge    = 0;
    int startCount = 0;

    he_hssi_kpi_csr_if csr_if ();

    he_hssi_kpi_csr #(
        .TS_W(32), .CNT_W(32), .LEN_W(LEN_W), .LEN_RST(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .csr(csr_if),
        .tg_num_pkt_o(tg_num_pkt),
        .tg_pattern_o(tg_pattern),
        .tg_pkt_len_o(tg_pkt_len),
        .tg_start_o(tg_start),
        .tg_pkt_sent_i(tg_pkt_sent),
        .tm_pkt_good_i(tm_pkt_good),
        .tm_pkt_bad_i(tm_pkt_bad),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edgeNo++;
        if (tg_start === 1'b1) startCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Read responses must follow each accepted read by exactly one cycle
    always @(posedge clk) begin : monitor
        logic    rdWas;
        logic    rstWas;
        rd_exp_t e;
        rdWas  = csr_if.csr_rd;
        rstWas = rst;
        #1;
        checkOutput("rvalid", 32'(csr_if.csr_rvalid), 32'(rdWas && !rstWas));
        if (csr_if.csr_rvalid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL sb_underflow: observed=rvalid expected=no pending read");
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("rdata@%h", e.addr), csr_if.csr_rdata, e.data);
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRd,
                                 input logic sent, input logic good, input logic bad);
        rd_exp_t e;
        csr_if.csr_wr    = wr;
        csr_if.csr_rd    = rd;
        csr_if.csr_addr  = addr;
        csr_if.csr_wdata = wdata;
        tg_pkt_sent      = sent;
        tm_pkt_good      = good;
        tm_pkt_bad       = bad;
        if (rd && !rst) begin
            e.addr = addr;
            e.data = expRd;
            expQ.push_back(e);
        end
        @(negedge clk);
        csr_if.csr_wr    = 1'b0;
        csr_if.csr_rd    = 1'b0;
        csr_if.csr_addr  = '0;
        csr_if.csr_wdata = '0;
        tg_pkt_sent      = 1'b0;
        tm_pkt_good      = 1'b0;
        tm_pkt_bad       = 1'b0;
    endtask

    task automatic csrWrite(input logic [15:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, a, d, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic csrRead(input logic [15:0] a, input logic [31:0] exp);
        applyStimulus(1'b0, 1'b1, a, '0, exp, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // The timestamp a capture sees is the number of edges since the last reset edge, minus one
    task automatic pulse(input logic sent, input logic good, input logic bad, output logic [31:0] ts);
        ts = 32'(edgeNo - rstEdge);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, sent, good, bad);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : stimulus
        logic [31:0] t, tgEnd, tmStart, tmEnd;
        int          starts;
        csr_if.csr_wr    = 1'b0;
        csr_if.csr_rd    = 1'b0;
        csr_if.csr_addr  = '0;
        csr_if.csr_wdata = '0;
        tg_pkt_sent      = 1'b0;
        tm_pkt_good      = 1'b0;
        tm_pkt_bad       = 1'b0;
        rst              = 1'b1;
        repeat (2) @(negedge clk);
        rstEdge = edgeNo;
        rst     = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_tg_start", 32'(tg_start), 0);
        checkOutput("rst_rdata", csr_if.csr_rdata, 0);
        checkOutput("rst_num_pkt", tg_num_pkt, 0);
        checkOutput("rst_pattern", 32'(tg_pattern), 0);
        checkOutput("rst_pkt_len", 32'(tg_pkt_len), 64);
        csrRead(A_LEN, 64);
        csrRead(A_NUM, 0);
        csrRead(A_START, 0);
        csrRead(16'hE100, 0);

        $display("[TB] configuration");
        csrWrite(A_NUM, 4);
        csrWrite(A_PAT, 32'hFFFF_FFFF);
        csrRead(A_PAT, 3);
        csrWrite(A_PAT, 2);
        csrWrite(A_LEN, 128);
        csrWrite(A_GOOD, 32'h0000_FFFF);
        csrRead(A_GOOD, 0);
        csrRead(A_NUM, 4);
        checkOutput("cfg_num_pkt", tg_num_pkt, 4);
        checkOutput("cfg_pattern", 32'(tg_pattern), 2);
        checkOutput("cfg_pkt_len", 32'(tg_pkt_len), 128);

        $display("[TB] four-packet run");
        csrWrite(A_START, 1);
        checkOutput("start_pulse", 32'(tg_start), 1);
        checkOutput("start_busy", 32'(busy), 1);
        csrRead(A_START, 1);
        checkOutput("start_pulse_end", 32'(tg_start), 0);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0, 1'b0, t);
            idle(1);
        end
        tgEnd = t;
        pulse(1'b0, 1'b1, 1'b0, tmStart);
        idle(1);
        pulse(1'b0, 1'b1, 1'b0, t);
        pulse(1'b0, 1'b0, 1'b1, t);
        idle(1);
        checkOutput("run_busy_3rx", 32'(busy), 1);
        pulse(1'b0, 1'b1, 1'b0, tmEnd);
        checkOutput("run_done_busy", 32'(busy), 0);
        csrRead(A_TGEND, tgEnd);
        csrRead(A_TMST, tmStart);
        csrRead(A_TMEND, tmEnd);
        csrRead(A_GOOD, 3);
        csrRead(A_BAD, 1);
        csrRead(A_START, 2);
        checkOutput("start_count_1", 32'(startCount), 1);

        $display("[TB] two-packet run with mid-run start");
        applyStimulus(1'b1, 1'b1, A_NUM, 2, 4, 1'b0, 1'b0, 1'b0);
        csrWrite(A_START, 1);
        checkOutput("restart_pulse", 32'(tg_start), 1);
        pulse(1'b1, 1'b0, 1'b0, t);
        pulse(1'b1, 1'b0, 1'b0, tgEnd);
        starts = startCount;
        csrWrite(A_START, 1);
        checkOutput("midrun_no_pulse", 32'(tg_start), 0);
        checkOutput("midrun_busy", 32'(busy), 1);
        csrRead(A_TGEND, tgEnd);
        checkOutput("midrun_start_count", 32'(startCount), 32'(starts));
        pulse(1'b0, 1'b1, 1'b1, t);
        checkOutput("dual_rx_done", 32'(busy), 0);
        csrRead(A_GOOD, 1);
        csrRead(A_BAD, 1);
        csrRead(A_TMST, t);
        csrRead(A_TMEND, t);
        csrRead(A_START, 2);

        $display("[TB] zero-packet run");
        csrWrite(A_NUM, 0);
        csrWrite(A_START, 1);
        checkOutput("zero_pulse", 32'(tg_start), 1);
        checkOutput("zero_busy", 32'(busy), 1);
        idle(1);
        checkOutput("zero_done", 32'(busy), 0);
        pulse(1'b1, 1'b1, 1'b1, t);
        csrRead(A_GOOD, 0);
        csrRead(A_BAD, 0);
        csrRead(A_TGEND, 0);
        csrRead(A_TMST, 0);
        csrRead(A_TMEND, 0);
        csrRead(A_START, 2);

        $display("[TB] reset during run");
        csrWrite(A_NUM, 10);
        csrWrite(A_START, 1);
        pulse(1'b0, 1'b1, 1'b0, t);
        pulse(1'b0, 1'b1, 1'b0, t);
        csrWrite(A_LEN, 200);
        checkOutput("run_len_update", 32'(tg_pkt_len), 200);
        csrRead(A_GOOD, 2);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, A_NUM, '0, '0, 1'b0, 1'b0, 1'b0);
        rstEdge = edgeNo;
        rst     = 1'b0;
        checkOutput("rst_run_busy", 32'(busy), 0);
        checkOutput("rst_run_len", 32'(tg_pkt_len), 64);
        checkOutput("rst_run_num", tg_num_pkt, 0);
        csrRead(A_GOOD, 0);
        csrRead(A_START, 0);
        csrRead(A_LEN, 64);

        idle(2);
        checkOutput("sb_drain", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/he_hssi_kpi_csr.md
Name: he_hssi_kpi_csr

Overview:
- CSR responder and KPI-statistics engine for the HE-HSSI traffic generator (TG) and traffic monitor (TM).
- Answers host reads and writes at the HE-HSSI KPI register offsets.
- Drives the TG configuration and start pulse, counts TX packets and good/bad RX packets, and captures free-running timestamps for latency and throughput measurement.
- Sits between the HE-HSSI CSR bridge and the TG/TM datapath.

Parameters:
- TS_W, 32, timestamp counter width (≤32)
- CNT_W, 32, packet counter width (≤32)
- LEN_W, 14, packet length field width
- LEN_RST, 64, reset value of PKT_LEN

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- csr_addr  in  16  byte address, low 16 bits of the block offset
- csr_wr  in  1  write strobe, one cycle
- csr_rd  in  1  read strobe, one cycle
- csr_wdata  in  32  write data
- csr_rdata  out  32  read data
- csr_rvalid  out  1  read data valid
- tg_num_pkt  out  32  NUM_PKT register
- tg_pattern  out  2  DATA_PATTERN[1:0]
- tg_pkt_len  out  LEN_W  PKT_LEN register
- tg_start  out  1  one-cycle start pulse to TG
- tg_pkt_sent  in  1  TG sent one packet
- tm_pkt_good  in  1  TM received a good packet
- tm_pkt_bad  in  1  TM received a bad packet
- busy  out  1  test running

Behaviour:
- Register map (byte offsets):
  - E000 NUM_PKT: RW, reset 0.
  - E008 DATA_PATTERN: RW [1:0], reset 0.
  - E00C START_XFR: write bit0=1 starts a test; reads return {30'b0, done, busy}.
  - E034 PKT_LEN: RW [LEN_W-1:0], reset LEN_RST.
  - E3D0 TG_END_TS: RO.
  - E404 TM_PKT_GOOD: RO.
  - E408 TM_PKT_BAD: RO.
  - E42C TM_START_TS: RO.
  - E430 TM_END_TS: RO.
- Unmapped reads return 0. Writes to RO or unmapped addresses are ignored. RO and narrow fields are zero-extended on read.
- Read latency: csr_rvalid asserts exactly 1 cycle after csr_rd, with csr_rdata registered. csr_rdata holds its value until the next read. Back-to-back reads are supported every cycle. Simultaneous csr_rd and csr_wr to the same register returns the pre-write value.
- Timestamp: ts counter increments every cycle from 0 after reset and wraps modulo 2^TS_W.
- Internal tx_cnt counts tg_pkt_sent. The good/bad counters count tm_pkt_good/tm_pkt_bad. rx_total = good + bad.
- All counters saturate at all-ones and never wrap.
- Good and bad in the same cycle both increment, so rx_total advances by 2.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE → RUN on a START_XFR write with bit0=1.
    - That cycle: tg_start=1 for exactly one cycle.
    - tx_cnt, good, bad and all captured timestamps clear to 0, and done clears.
    - Config writes in the same cycle are not visible in tg_* until the next cycle.
  - RUN:
    - When tx_cnt reaches NUM_PKT on a tg_pkt_sent, capture TG_END_TS = ts.
    - On the first RX pulse (good or bad) after start, capture TM_START_TS = ts.
    - On every RX pulse, update TM_END_TS = ts.
  - RUN → DONE when rx_total ≥ NUM_PKT after the update. done=1 and busy=0.
  - NUM_PKT=0: start goes RUN → DONE on the next cycle with no captures.
- A START_XFR write during RUN is ignored: no pulse, no clear.
- Config register writes during RUN are accepted and reflected on the tg_* outputs, but the TG samples them only at tg_start.
- tg_pkt_sent, tm_pkt_good and tm_pkt_bad in IDLE/DONE are ignored and do not count.
- Reset values of outputs: csr_rdata=0, csr_rvalid=0, tg_start=0, busy=0, tg_num_pkt=0, tg_pattern=0, tg_pkt_len=LEN_RST.
- Reset mid-RUN returns to IDLE within 1 cycle, clears all stats, and drops any pending rvalid.

Test Plan:
- Reset, then read E034, E000, E00C:
  - rvalid one cycle after each rd.
  - Data 64, 0, 0.
  - Read of unmapped E100 returns 0.
- Write NUM_PKT=4, PKT_LEN=128, then START_XFR=1:
  - tg_start is high exactly 1 cycle.
  - busy=1.
  - tg_num_pkt=4, tg_pkt_len=128.
- In RUN, drive 4 tg_pkt_sent pulses, then 3 good and 1 bad RX pulses at known ts:
  - TG_END_TS = ts at 4th send.
  - TM_START_TS = ts at 1st RX, TM_END_TS = ts at last RX.
  - GOOD=3, BAD=1.
  - E00C reads 2 (done).
- With NUM_PKT=2, drive good and bad in the same cycle:
  - GOOD=1, BAD=1, DONE in that cycle's update.
  - A START write mid-RUN (before the RX) produces no tg_start and no clear.
- Start with NUM_PKT=0:
  - DONE one cycle later, all stats 0.
  - Restart from DONE clears the previous counts.
- Assert rst mid-RUN after 2 good packets:
  - busy=0, GOOD=0, PKT_LEN=64 after reset.
  - No rvalid from a read issued in the reset cycle.
